// File: rtl/mmss_timer_ctrl.sv
// MM:SS BCD timer with run/pause FSM, up/down count, preset load and wrap/saturate at 59:59.
// Optional lap freeze of the displayed digits when MMSS_TIMER_LAP_EN is defined.
module mmss_timer_ctrl #(
    parameter int unsigned TICK_DIV = 100000000,
    parameter int unsigned WRAP     = 1,
    parameter int unsigned DIV_W    = 27
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        mode_down,
    input  logic        load,
    input  logic [13:0] load_digits,
`ifdef MMSS_TIMER_LAP_EN
    input  logic        lap,
    output logic        lap_valid,
`endif
    output logic [3:0]  digitSeconds,
    output logic [2:0]  tensSeconds,
    output logic [3:0]  digitMinutes,
    output logic [2:0]  tensMinutes,
    output logic        running,
    output logic        tick,
    output logic        done
);

    typedef enum logic [1:0] {StIdle, StRun, StPause, StExpired} state_e;

    localparam logic [DIV_W-1:0] PrescMax = DIV_W'(TICK_DIV - 1);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic             mode_q, mode_d;
    logic [3:0]       ds_q, ds_d, dm_q, dm_d;
    logic [2:0]       ts_q, ts_d, tm_q, tm_d;

    logic [3:0] ds_up, dm_up, ds_dn, dm_dn, ld_ds, ld_dm;
    logic [2:0] ts_up, tm_up, ts_dn, tm_dn, ld_ts, ld_tm;
    logic       at_max, is_zero, dn_zero;
    logic [13:0] live;

    assign live    = {tm_q, dm_q, ts_q, ds_q};
    assign at_max  = (tm_q == 3'd5) && (dm_q == 4'd9) && (ts_q == 3'd5) && (ds_q == 4'd9);
    assign is_zero = (live == 14'd0);
    assign dn_zero = ({tm_dn, dm_dn, ts_dn, ds_dn} == 14'd0);

    // Out-of-range preset fields clamp to their maximum legal value.
    assign ld_tm = (load_digits[13:11] > 3'd5) ? 3'd5 : load_digits[13:11];
    assign ld_dm = (load_digits[10:7]  > 4'd9) ? 4'd9 : load_digits[10:7];
    assign ld_ts = (load_digits[6:4]   > 3'd5) ? 3'd5 : load_digits[6:4];
    assign ld_ds = (load_digits[3:0]   > 4'd9) ? 4'd9 : load_digits[3:0];

    always_comb begin
        ds_up = ds_q + 4'd1;
        ts_up = ts_q;
        dm_up = dm_q;
        tm_up = tm_q;
        if (ds_q == 4'd9) begin
            ds_up = 4'd0;
            if (ts_q == 3'd5) begin
                ts_up = 3'd0;
                if (dm_q == 4'd9) begin
                    dm_up = 4'd0;
                    tm_up = tm_q + 3'd1;
                end else begin
                    dm_up = dm_q + 4'd1;
                end
            end else begin
                ts_up = ts_q + 3'd1;
            end
        end
    end

    always_comb begin
        ds_dn = ds_q - 4'd1;
        ts_dn = ts_q;
        dm_dn = dm_q;
        tm_dn = tm_q;
        if (ds_q == 4'd0) begin
            ds_dn = 4'd9;
            if (ts_q == 3'd0) begin
                ts_dn = 3'd5;
                if (dm_q == 4'd0) begin
                    dm_dn = 4'd9;
                    tm_dn = tm_q - 3'd1;
                end else begin
                    dm_dn = dm_q - 4'd1;
                end
            end else begin
                ts_dn = ts_q - 3'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        mode_d  = mode_q;
        ds_d    = ds_q;
        ts_d    = ts_q;
        dm_d    = dm_q;
        tm_d    = tm_q;
        if (load) begin
            {tm_d, dm_d, ts_d, ds_d} = {ld_tm, ld_dm, ld_ts, ld_ds};
            presc_d = '0;
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && !stop) begin
                        mode_d = mode_down;
                        if (mode_down && is_zero) begin
                            state_d = StExpired;
                            done_d  = 1'b1;
                        end else begin
                            state_d = StRun;
                        end
                    end
                end
                StRun: begin
                    // stop freezes the prescaler on the same edge so resume continues it
                    if (stop) begin
                        state_d = StPause;
                    end else if (presc_q == PrescMax) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                    if (tick_q) begin
                        if (!mode_q) begin
                            if (!at_max) begin
                                {tm_d, dm_d, ts_d, ds_d} = {tm_up, dm_up, ts_up, ds_up};
                            end else if (WRAP != 0) begin
                                {tm_d, dm_d, ts_d, ds_d} = 14'd0;
                            end else begin
                                state_d = StExpired;
                                done_d  = 1'b1;
                            end
                        end else begin
                            {tm_d, dm_d, ts_d, ds_d} = {tm_dn, dm_dn, ts_dn, ds_dn};
                            if (dn_zero) begin
                                state_d = StExpired;
                                done_d  = 1'b1;
                            end
                        end
                    end
                end
                StPause: begin
                    if (start && !stop) begin
                        state_d = StRun;
                    end
                end
                StExpired: begin
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            presc_q <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
            mode_q  <= 1'b0;
            ds_q    <= 4'd0;
            ts_q    <= 3'd0;
            dm_q    <= 4'd0;
            tm_q    <= 3'd0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
            mode_q  <= mode_d;
            ds_q    <= ds_d;
            ts_q    <= ts_d;
            dm_q    <= dm_d;
            tm_q    <= tm_d;
        end
    end

    assign running = (state_q == StRun);
    assign tick    = tick_q;
    assign done    = done_q;

`ifdef MMSS_TIMER_LAP_EN
    logic        lap_prev_q, lap_q;
    logic [13:0] frz_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lap_prev_q <= 1'b0;
            lap_q      <= 1'b0;
            frz_q      <= 14'd0;
        end else begin
            lap_prev_q <= lap;
            if (load || (state_d == StExpired && state_q != StExpired)) begin
                lap_q <= 1'b0;
            end else if (lap && !lap_prev_q) begin
                if (lap_q) begin
                    lap_q <= 1'b0;
                end else if (state_q == StRun) begin
                    lap_q <= 1'b1;
                    frz_q <= live;
                end
            end
        end
    end

    assign lap_valid = lap_q;
    assign {tensMinutes, digitMinutes, tensSeconds, digitSeconds} = lap_q ? frz_q : live;
`else
    assign {tensMinutes, digitMinutes, tensSeconds, digitSeconds} = live;
`endif

endmodule

// File: tb/tb_mmss_timer_ctrl.sv
// Directed bench for mmss_timer_ctrl: scoreboard queue of expected values, immediate-assertion checks.
// Two instances share stimulus: one wraps at 59:59, the other saturates.
module tb_mmss_timer_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, stop, mode_down, load;
    logic [13:0] load_digits;
    logic [3:0]  w_ds, w_dm, s_ds, s_dm;
    logic [2:0]  w_ts, w_tm, s_ts, s_tm;
    logic        w_run, w_tick, w_done, s_run, s_tick, s_done;
`ifdef MMSS_TIMER_LAP_EN
    logic        lap;
    logic        w_lapv, s_lapv;
`endif

    always #5 clk = ~clk;

    mmss_timer_ctrl #(.TICK_DIV(4), .WRAP(1), .DIV_W(4)) u_wrap (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .mode_down(mode_down),
        .load(load), .load_digits(load_digits),
`ifdef MMSS_TIMER_LAP_EN
        .lap(lap), .lap_valid(w_lapv),
`endif
        .digitSeconds(w_ds), .tensSeconds(w_ts), .digitMinutes(w_dm), .tensMinutes(w_tm),
        .running(w_run), .tick(w_tick), .done(w_done)
    );

    mmss_timer_ctrl #(.TICK_DIV(4), .WRAP(0), .DIV_W(4)) u_sat (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .mode_down(mode_down),
        .load(load), .load_digits(load_digits),
`ifdef MMSS_TIMER_LAP_EN
        .lap(lap), .lap_valid(s_lapv),
`endif
        .digitSeconds(s_ds), .tensSeconds(s_ts), .digitMinutes(s_dm), .tensMinutes(s_tm),
        .running(s_run), .tick(s_tick), .done(s_done)
    );

    logic [13:0] w_dig, s_dig;
    logic [2:0]  w_flags, s_flags;
    assign w_dig   = {w_tm, w_dm, w_ts, w_ds};
    assign s_dig   = {s_tm, s_dm, s_ts, s_ds};
    assign w_flags = {w_tick, w_run, w_done};
    assign s_flags = {s_tick, s_run, s_done};

    int w_done_n = 0;
    always @(posedge clk) if (w_done) w_done_n <= w_done_n + 1;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;

    function automatic logic [13:0] mmss(input int m, input int s);
        return {3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
    endfunction

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sbq.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sbq.size() == 0) begin
            failures++;
            $error("FAIL sb_empty observed=%0h expected=<none>", obs);
        end else begin
            e = sbq.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!w_tick && n < 16);
        if (!w_tick) begin
            checks++;
            failures++;
            $error("FAIL tick_timeout observed=0 expected=1");
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_pulse(input logic [13:0] d);
        load_digits = d;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tk;
        reset = 1'b1; start = 1'b0; stop = 1'b0; mode_down = 1'b0; load = 1'b0;
        load_digits = 14'd0;
`ifdef MMSS_TIMER_LAP_EN
        lap = 1'b0;
`endif
        repeat (3) @(negedge clk);
        push("rst_dig", 32'(14'd0));
        push("rst_flags", 32'(3'b000));
        push("rst_sat_dig", 32'(14'd0));
        reset = 1'b0;
        pop_check(32'(w_dig));
        pop_check(32'(w_flags));
        pop_check(32'(s_dig));

        // Up count: tick latency, first update, minute carry
        mode_down = 1'b0;
        pulse_start();
        push("t1_running", 32'(3'b010));
        pop_check(32'(w_flags));
        repeat (3) @(negedge clk);
        push("t1_pre_tick", 32'(3'b010));
        pop_check(32'(w_flags));
        @(negedge clk);
        push("t1_tick", 32'(3'b110));
        push("t1_dig_hold", 32'(14'd0));
        pop_check(32'(w_flags));
        pop_check(32'(w_dig));
        @(negedge clk);
        push("t1_0001", 32'(mmss(0, 1)));
        pop_check(32'(w_dig));
        repeat (59) begin
            wait_tick();
            @(negedge clk);
        end
        push("t1_0100", 32'(mmss(1, 0)));
        pop_check(32'(w_dig));

        // 59:59 wrap vs saturate
        load_pulse(mmss(59, 58));
        push("t2_load", 32'(mmss(59, 58)));
        push("t2_load_flags", 32'(3'b000));
        pop_check(32'(w_dig));
        pop_check(32'(w_flags));
        pulse_start();
        wait_tick();
        @(negedge clk);
        push("t2_wrap_5959", 32'(mmss(59, 59)));
        push("t2_sat_5959", 32'(mmss(59, 59)));
        pop_check(32'(w_dig));
        pop_check(32'(s_dig));
        wait_tick();
        @(negedge clk);
        push("t2_wrap_dig", 32'(14'd0));
        push("t2_wrap_flags", 32'(3'b010));
        push("t2_sat_dig", 32'(mmss(59, 59)));
        push("t2_sat_flags", 32'(3'b001));
        pop_check(32'(w_dig));
        pop_check(32'(w_flags));
        pop_check(32'(s_dig));
        pop_check(32'(s_flags));
        @(negedge clk);
        push("t2_sat_done_pulse", 32'(3'b000));
        push("t2_wrap_no_done", 32'(0));
        pop_check(32'(s_flags));
        pop_check(32'(w_done_n));

        // Down count from 01:00; mode change while running must be ignored
        mode_down = 1'b1;
        load_pulse(mmss(1, 0));
        pulse_start();
        mode_down = 1'b0;
        wait_tick();
        @(negedge clk);
        push("t3_0059", 32'(mmss(0, 59)));
        pop_check(32'(w_dig));
        repeat (58) begin
            wait_tick();
            @(negedge clk);
        end
        push("t3_0001", 32'(mmss(0, 1)));
        pop_check(32'(w_dig));
        wait_tick();
        push("t3_last_tick", 32'(3'b110));
        pop_check(32'(w_flags));
        @(negedge clk);
        push("t3_zero", 32'(14'd0));
        push("t3_done", 32'(3'b001));
        pop_check(32'(w_dig));
        pop_check(32'(w_flags));
        @(negedge clk);
        push("t3_done_once", 32'(3'b000));
        pop_check(32'(w_flags));
        pulse_start();
        repeat (5) @(negedge clk);
        push("t3_start_ignored", 32'(3'b000));
        pop_check(32'(w_flags));
        load_pulse(mmss(0, 5));
        push("t3_load_0005", 32'(mmss(0, 5)));
        pop_check(32'(w_dig));
        pulse_start();
        push("t3_idle_restart", 32'(3'b010));
        pop_check(32'(w_flags));
        mode_down = 1'b1;
        load_pulse(14'd0);
        pulse_start();
        push("t3_zero_start", 32'(3'b001));
        pop_check(32'(w_flags));
        load_pulse(14'h3fff);
        push("t3_clamp_all", 32'(mmss(59, 59)));
        pop_check(32'(w_dig));
        load_pulse({3'd6, 4'd3, 3'd2, 4'd12});
        push("t3_clamp_mix", 32'(mmss(53, 29)));
        pop_check(32'(w_dig));

        // Pause keeps the partial prescaler interval
        mode_down = 1'b0;
        load_pulse(14'd0);
        pulse_start();
        repeat (2) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        push("t4_paused", 32'(3'b000));
        pop_check(32'(w_flags));
        tk = 0;
        repeat (20) begin
            @(negedge clk);
            if (w_tick) tk++;
        end
        push("t4_no_tick", 32'(0));
        push("t4_dig_frozen", 32'(14'd0));
        pop_check(32'(tk));
        pop_check(32'(w_dig));
        pulse_start();
        push("t4_resume", 32'(3'b010));
        pop_check(32'(w_flags));
        @(negedge clk);
        push("t4_tick_not_yet", 32'(3'b010));
        pop_check(32'(w_flags));
        @(negedge clk);
        push("t4_tick_2cyc", 32'(3'b110));
        pop_check(32'(w_flags));
        @(negedge clk);
        push("t4_0001", 32'(mmss(0, 1)));
        pop_check(32'(w_dig));

        // Same-cycle priorities and mid-count reset
        load_pulse(14'd0);
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        push("t5_start_stop_idle", 32'(3'b000));
        pop_check(32'(w_flags));
        repeat (3) @(negedge clk);
        push("t5_still_idle", 32'(3'b000));
        pop_check(32'(w_flags));
        pulse_start();
        repeat (2) @(negedge clk);
        load_digits = mmss(12, 34);
        load = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        load = 1'b0;
        stop = 1'b0;
        push("t5_load_stop_dig", 32'(mmss(12, 34)));
        push("t5_load_stop_flags", 32'(3'b000));
        pop_check(32'(w_dig));
        pop_check(32'(w_flags));
        pulse_start();
        wait_tick();
        @(negedge clk);
        push("t5_1235", 32'(mmss(12, 35)));
        pop_check(32'(w_dig));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        push("t5_reset_dig", 32'(14'd0));
        push("t5_reset_flags", 32'(3'b000));
        pop_check(32'(w_dig));
        pop_check(32'(w_flags));

`ifdef MMSS_TIMER_LAP_EN
        mode_down = 1'b0;
        pulse_start();
        repeat (7) begin
            wait_tick();
            @(negedge clk);
        end
        push("t6_0007", 32'(mmss(0, 7)));
        pop_check(32'(w_dig));
        lap = 1'b1;
        @(negedge clk);
        lap = 1'b0;
        push("t6_lap_valid", 32'(1));
        pop_check(32'(w_lapv));
        repeat (5) begin
            wait_tick();
            @(negedge clk);
        end
        push("t6_frozen", 32'(mmss(0, 7)));
        pop_check(32'(w_dig));
        lap = 1'b1;
        @(negedge clk);
        lap = 1'b0;
        push("t6_live", 32'(mmss(0, 12)));
        push("t6_lap_clear", 32'(0));
        pop_check(32'(w_dig));
        pop_check(32'(w_lapv));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
